medidor_clock: RTL

MEDIDOR_CLOCK -- requirements
Module: medidor_clock

---
 rtl/medidor_clock.sv | 131 +++++++++++++
 1 files changed

// File: rtl/medidor_clock.sv
// medidor_clock: measures the period of a slow clock (clock_med) in
// clock_in cycles, with a synchronizer, overrun and timeout flags.
module medidor_clock #(
    parameter int LARGURA = 26,
    parameter int SINC    = 2
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               clock_med,
    input  logic               habilita,
    input  logic               ack,
    output logic               tick,
    output logic [LARGURA-1:0] periodo,
    output logic               valido,
    output logic               estouro,
    output logic               timeout
);

    typedef enum logic [1:0] {
        OCIOSO,
        ARMADO,
        MEDINDO
    } estado_t;

    // Last count value before saturation: 2^LARGURA-2.
    localparam logic [LARGURA-1:0] LIMITE = {{(LARGURA-1){1'b1}}, 1'b0};
    localparam logic [LARGURA-1:0] UM     = {{(LARGURA-1){1'b0}}, 1'b1};

    estado_t            r_estado;
    estado_t            w_prox_estado;
    logic [SINC-1:0]    r_sinc;
    logic               r_hist;
    logic               r_hab_ant;
    logic [LARGURA-1:0] r_cont;
    logic [LARGURA-1:0] w_prox_cont;
    logic [LARGURA-1:0] r_periodo;
    logic               r_valido;
    logic               r_estouro;
    logic               r_timeout;
    logic               w_sobe;
    logic               w_resultado;
    logic               w_satura;
    logic               w_hab_sobe;

    assign w_sobe     = r_sinc[SINC-1] & ~r_hist;
    assign w_hab_sobe = habilita & ~r_hab_ant;

    assign tick    = w_sobe;
    assign periodo = r_periodo;
    assign valido  = r_valido;
    assign estouro = r_estouro;
    assign timeout = r_timeout;

    // Synchronizer chain plus history bit for rising-edge detection.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_sinc <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sinc <= {r_sinc[SINC-2:0], clock_med};
            r_hist <= r_sinc[SINC-1];
        end
    end

    // FSM state and period counter registers.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_estado <= OCIOSO;
            r_cont   <= '0;
        end else begin
            r_estado <= w_prox_estado;
            r_cont   <= w_prox_cont;
        end
    end

    // Next state, next count, result and saturation strobes.
    always_comb begin
        w_prox_estado = r_estado;
        w_prox_cont   = '0;
        w_resultado   = 1'b0;
        w_satura      = 1'b0;
        if (!habilita) begin
            w_prox_estado = OCIOSO;
        end else begin
            case (r_estado)
                OCIOSO: w_prox_estado = ARMADO;
                ARMADO: begin
                    if (w_sobe) w_prox_estado = MEDINDO;
                end
                MEDINDO: begin
                    if (w_sobe) begin
                        w_resultado = 1'b1;
                    end else if (r_cont == LIMITE) begin
                        w_satura      = 1'b1;
                        w_prox_estado = ARMADO;
                    end else begin
                        w_prox_cont = r_cont + UM;
                    end
                end
                default: w_prox_estado = OCIOSO;
            endcase
        end
    end

    // Result register, handshake and sticky flags.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_hab_ant <= 1'b0;
            r_periodo <= '0;
            r_valido  <= 1'b0;
            r_estouro <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_hab_ant <= habilita;
            if (w_resultado) begin
                r_periodo <= r_cont + UM;
                r_valido  <= 1'b1;
            end else if (ack) begin
                r_valido <= 1'b0;
            end
            if (w_hab_sobe) begin
                r_estouro <= 1'b0;
                r_timeout <= 1'b0;
            end else begin
                if (w_resultado && r_valido && !ack) r_estouro <= 1'b1;
                if (w_satura) r_timeout <= 1'b1;
            end
        end
    end

endmodule
